biriscv_regfile_mrnw: RTL and testbench
=======================================

// Module: biriscv_regfile_mrnw
// PURPOSE
//   Parametrised multi-read/multi-write integer register file; successor to the 2R1W bank.
//   Serves dual-issue writeback: NUM_WR write ports and NUM_RD async read ports.
//   x0 is hardwired to zero. A post-reset sweep zeroes every register; ready_o marks completion.
// PARAMETERS
//   DATA_W    32  register width in bits
//   NUM_REGS  32  number of architectural registers; power of 2, >=4
//   NUM_RD    4   number of read ports
//   NUM_WR    2   number of write ports; higher index = younger instruction
//   ADDR_W    $clog2(NUM_REGS)  derived; do not override
// PORTS
//   clk_i      in   1               clock, rising edge
//   rst_ni     in   1               async reset, active-low
//   ready_o    out  1               1 = init sweep done; writes accepted
//   wr_en_i    in   NUM_WR          per-port write enable
//   wr_addr_i  in   NUM_WR*ADDR_W   packed write addresses, port 0 in LSBs
//   wr_data_i  in   NUM_WR*DATA_W   packed write data
//   rd_addr_i  in   NUM_RD*ADDR_W   packed read addresses
//   rd_data_o  out  NUM_RD*DATA_W   packed read data, combinational from rd_addr_i
// BEHAVIOUR
//   Reset (rst_ni=0, any time, incl. mid-sweep): FSM=INIT, clr_idx=1, ready_o=0. Storage is not reset.
//   INIT: each cycle writes 0 to reg[clr_idx], clr_idx++; all wr_en_i ignored.
//     After reg[NUM_REGS-1] is cleared: FSM=READY, ready_o=1 on the next edge.
//     Sweep takes NUM_REGS-1 cycles after rst_ni deasserts (31 at default).
//   INIT: all rd_data_o read 0.
//   READY: write on rising edge when wr_en_i[p]=1 and wr_addr_i[p]!=0; writes to x0 are dropped.
//   Write collision (two enabled ports, same addr): highest port index wins; others dropped, no error.
//   Different-address writes in the same cycle all commit.
//   Read: rd_data_o[r] = 0 if rd_addr_i[r]==0, else reg[rd_addr_i[r]]. No read latency.
//   Read/write same addr, same cycle: governed by BIRISCV_RF_BYPASS_EN (see CONFIGURATION).
//   FSM states: INIT -> READY when clr_idx==NUM_REGS-1. READY is terminal until reset.
//   clr_idx width ADDR_W; must not wrap to 0 (x0 is never written).
// CONFIGURATION
//   BIRISCV_RF_BYPASS_EN defined:
//     rd_data_o[r] forwards wr_data_i of the highest-index enabled port whose wr_addr matches
//     rd_addr_i[r] (!=0), in the same cycle. Only in READY.
//   Undefined:
//     reads return the pre-edge stored value; new data is visible the cycle after the write edge.
//   Addr 0 reads return 0 in both builds.
// STRUCTURE
//   Package biriscv_rf_pkg:
//     FSM state encoding RF_INIT=1'b0, RF_READY=1'b1.
//     Helper function for packed-slice extraction.
//     Default width constants.
//   Sub-module biriscv_regfile_rdport (one per read port via generate):
//     addr decode, x0 zeroing, INIT gating, optional bypass mux.
//   Top holds storage flops, write-priority logic and init FSM/counter.
// TESTING
//   1. Reset release:
//      rst_ni 0->1; ready_o=0 for exactly 31 cycles, then 1.
//      All 4 reads of x1..x31 return 0 afterwards.
//   2. Basic write/read:
//      wr0 x5=0xDEADBEEF, wr1 x6=0x12345678 same cycle.
//      Next cycle, rd x5/x6/x0/x7 -> 0xDEADBEEF/0x12345678/0/0.
//   3. Collision:
//      wr0 x9=0x11111111 and wr1 x9=0x22222222 same cycle -> x9 reads 0x22222222.
//      Write to x0 with 0xFFFFFFFF -> x0 reads 0.
//   4. Bypass:
//      wr1 x12=0xCAFEF00D while rd0 addr=12.
//      With macro -> 0xCAFEF00D same cycle; without -> old value, then 0xCAFEF00D next cycle.
//   5. Reset mid-sweep:
//      Assert rst_ni at sweep cycle 10 for 1 cycle -> ready_o stays 0.
//      Full 31-cycle sweep restarts; writes issued during INIT have no effect.
//   6. Params NUM_REGS=16, NUM_RD=2, NUM_WR=3:
//      Sweep is 15 cycles; 3-way collision on x3 -> port 2 data wins.

Source files
------------

// File: rtl/biriscv_rf_pkg.sv
// Shared types and constants for the multi-read/multi-write integer register file.
// Optional same-cycle write-to-read forwarding is enabled by defining BIRISCV_RF_BYPASS_EN.
package biriscv_rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_RD   = 4;
    localparam int RF_NUM_WR   = 2;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // LSB position of element idx inside a packed bus of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/biriscv_regfile_rdport.sv
// One asynchronous read port: x0 zeroing, gating while the init sweep runs and,
// when BIRISCV_RF_BYPASS_EN is defined, forwarding of same-cycle write data.
module biriscv_regfile_rdport
    import biriscv_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                             ready_i,
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic [NUM_WR-1:0]                wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]         wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]         wr_data_i,
    input  logic [NUM_REGS-1:1][DATA_W-1:0]  regs_i,
    output logic [DATA_W-1:0]                rd_data_o
);

    always_comb begin
        // NOTE: every path of a combinational block must assign its outputs; the default here prevents a latch.
        rd_data_o = '0;
        if (ready_i && (rd_addr_i != '0)) begin
            rd_data_o = regs_i[rd_addr_i];
`ifdef BIRISCV_RF_BYPASS_EN
            // Ascending scan so the youngest matching writer is forwarded.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[slice_lsb(p, ADDR_W) +: ADDR_W] == rd_addr_i)) begin
                    rd_data_o = wr_data_i[slice_lsb(p, DATA_W) +: DATA_W];
                end
            end
`endif
        end
    end

`ifndef BIRISCV_RF_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: rtl/biriscv_regfile_mrnw.sv
// Parametrised NUM_RD-read / NUM_WR-write integer register file with x0 hardwired to zero
// and a post-reset clearing sweep. Define BIRISCV_RF_BYPASS_EN for same-cycle read forwarding.
module biriscv_regfile_mrnw
    import biriscv_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      ready_o,
    input  logic [NUM_WR-1:0]         wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]  wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]  rd_data_o
);

    rf_state_e                        state_q;
    logic [ADDR_W-1:0]                clr_idx_q;
    logic [NUM_REGS-1:1][DATA_W-1:0]  regs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_ni) begin
            state_q   <= RF_INIT;
            clr_idx_q <= ADDR_W'(1);
        end else if (state_q == RF_INIT) begin
            if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                state_q <= RF_READY;
            end else begin
                clr_idx_q <= clr_idx_q + ADDR_W'(1);
            end
        end
    end

    assign ready_o = (state_q == RF_READY);

    // NOTE: storage has no reset; the sweep clears it, keeping the array free of reset fan-out.
    always_ff @(posedge clk_i) begin
        if (state_q == RF_INIT) begin
            regs_q[clr_idx_q] <= '0;
        end else begin
            // A later port's assignment overrides an earlier one, so the youngest writer wins.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[slice_lsb(p, ADDR_W) +: ADDR_W] != '0)) begin
                    regs_q[wr_addr_i[slice_lsb(p, ADDR_W) +: ADDR_W]] <=
                        wr_data_i[slice_lsb(p, DATA_W) +: DATA_W];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        biriscv_regfile_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR),
            .ADDR_W   (ADDR_W)
        ) u_rdport (
            .ready_i   (ready_o),
            .rd_addr_i (rd_addr_i[r*ADDR_W +: ADDR_W]),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .regs_i    (regs_q),
            .rd_data_o (rd_data_o[r*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_biriscv_regfile_mrnw.sv
// Bench for the register file: default 4R2W instance checked every cycle against an
// array model, plus a 16-entry 2R3W instance checked with directed literals.
module tb_biriscv_regfile_mrnw;

    logic clk;
    logic rst_n;

    // Default instance (32 regs, 4 read, 2 write)
    logic         ready;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;

    // Small instance (16 regs, 2 read, 3 write)
    logic         ready2;
    logic [2:0]   wr_en2;
    logic [11:0]  wr_addr2;
    logic [95:0]  wr_data2;
    logic [7:0]   rd_addr2;
    logic [63:0]  rd_data2;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    biriscv_regfile_mrnw dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ready_o   (ready),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    biriscv_regfile_mrnw #(
        .NUM_REGS (16),
        .NUM_RD   (2),
        .NUM_WR   (3)
    ) dut2 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ready_o   (ready2),
        .wr_en_i   (wr_en2),
        .wr_addr_i (wr_addr2),
        .wr_data_i (wr_data2),
        .rd_addr_i (rd_addr2),
        .rd_data_o (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    logic [31:0] m_mem [32];
    int          m_cycles;
    bit          m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cycles <= 0;
            m_rdy    <= 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
        end else if (!m_rdy) begin
            m_cycles <= m_cycles + 1;
            if (m_cycles + 1 == 31) m_rdy <= 1'b1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) m_mem[wr_addr[p*5 +: 5]] <= wr_data[p*32 +: 32];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model ready", {31'b0, ready}, {31'b0, m_rdy});
            for (int r = 0; r < 4; r++) begin
                logic [4:0]  a;
                logic [31:0] e;
                a = rd_addr[r*5 +: 5];
                e = 32'h0;
                if (m_rdy && a != 5'd0) begin
                    e = m_mem[a];
`ifdef BIRISCV_RF_BYPASS_EN
                    for (int p = 0; p < 2; p++) begin
                        if (wr_en[p] && wr_addr[p*5 +: 5] == a) e = wr_data[p*32 +: 32];
                    end
`endif
                end
                check($sformatf("model rd%0d addr %0d", r, a), rd_data[r*32 +: 32], e);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts negedges with ready low until both instances are ready (bounded).
    task automatic measure_sweep(output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ready)  c1++;
            if (!ready2) c2++;
            if (ready && ready2) break;
        end
        #1;
    endtask

    int c1, c2;

    initial begin
        rst_n    = 1'b0;
        wr_en    = '0; wr_addr  = '0; wr_data  = '0; rd_addr  = '0;
        wr_en2   = '0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
        repeat (3) tick();
        cmp_en = 1'b1;
        repeat (2) tick();

        // 1. Reset release and sweep length
        rst_n = 1'b1;
        measure_sweep(c1, c2);
        check("sweep cycles 32 regs", c1, 32'd31);
        check("sweep cycles 16 regs", c2, 32'd15);
        for (int a = 1; a < 32; a += 4) begin
            for (int r = 0; r < 4; r++) rd_addr[r*5 +: 5] = 5'((a + r) % 32);
            @(negedge clk);
            for (int r = 0; r < 4; r++) check($sformatf("cleared rd%0d", r), rd_data[r*32 +: 32], 32'h0);
            tick();
        end

        // 2. Two different-address writes in one cycle
        wr_en   = 2'b11;
        wr_addr = {5'd6, 5'd5};
        wr_data = {32'h12345678, 32'hDEADBEEF};
        tick();
        wr_en   = 2'b00;
        rd_addr = {5'd7, 5'd0, 5'd6, 5'd5};
        @(negedge clk);
        check("x5", rd_data[31:0],   32'hDEADBEEF);
        check("x6", rd_data[63:32],  32'h12345678);
        check("x0", rd_data[95:64],  32'h0);
        check("x7", rd_data[127:96], 32'h0);
        tick();

        // 3. Collision and x0 write
        wr_en   = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h22222222, 32'h11111111};
        tick();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hFFFFFFFF};
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd9};
        @(negedge clk);
        check("collision x9", rd_data[31:0], 32'h22222222);
        check("x0 during write", rd_data[63:32], 32'h0);
        tick();
        wr_en = 2'b00;
        @(negedge clk);
        check("x0 after write", rd_data[63:32], 32'h0);
        tick();

        // 4. Same-cycle read of a register being written
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd12};
        wr_data = {32'h0, 32'h01010101};
        tick();
        wr_en   = 2'b10;
        wr_addr = {5'd12, 5'd0};
        wr_data = {32'hCAFEF00D, 32'h0};
        rd_addr = {5'd0, 5'd0, 5'd0, 5'd12};
        @(negedge clk);
`ifdef BIRISCV_RF_BYPASS_EN
        check("bypass same cycle", rd_data[31:0], 32'hCAFEF00D);
`else
        check("no bypass same cycle", rd_data[31:0], 32'h01010101);
`endif
        tick();
        wr_en = 2'b00;
        @(negedge clk);
        check("x12 next cycle", rd_data[31:0], 32'hCAFEF00D);
        tick();

        // 6. Small instance: three-way collision
        wr_en2   = 3'b111;
        wr_addr2 = {4'd3, 4'd3, 4'd3};
        wr_data2 = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        tick();
        wr_en2   = 3'b000;
        rd_addr2 = {4'd0, 4'd3};
        @(negedge clk);
        check("dut2 collision x3", rd_data2[31:0],  32'hCCCCCCCC);
        check("dut2 x0",           rd_data2[63:32], 32'h0);
        tick();

        // 5. Reset mid-sweep, writes during INIT ignored
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("ready low in reset", {31'b0, ready}, 32'h0);
        tick();
        rst_n   = 1'b1;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'hAAAA5555};
        measure_sweep(c1, c2);
        check("restart sweep 32 regs", c1, 32'd31);
        check("restart sweep 16 regs", c2, 32'd15);
        wr_en   = 2'b00;
        rd_addr = {5'd0, 5'd12, 5'd5, 5'd7};
        @(negedge clk);
        check("x7 INIT write dropped", rd_data[31:0],  32'h0);
        check("x5 re-cleared",         rd_data[63:32], 32'h0);
        check("x12 re-cleared",        rd_data[95:64], 32'h0);
        tick();

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
